// File: rtl/tiny_cpu_p.sv
// tiny_cpu_p: multi-cycle RV32I-subset core with a built-in tick divider.
// The FSM advances one state per tick, so each instruction takes four ticks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | load IR from the instruction ROM at the current PC
// S_DECODE | latch operands and immediate, classify the instruction
// S_EXEC   | compute result and next PC, or stop on a halt condition
// S_WB     | write rd, update PC, count the retire, toggle led_blue
// S_HALT   | terminal; ignores ticks, only RST leaves it
module tiny_cpu_p #(
   parameter int    XLEN       = 32,
   parameter int    NREGS      = 16,
   parameter int    IMEM_DEPTH = 64,
   parameter string PROG_FILE  = "prog.hex",
   parameter int    CLK_DIV    = 12000000
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            run,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata,
   output logic [31:0]     dbg_pc,
   output logic [31:0]     dbg_ir,
   output logic [15:0]     retired,
   output logic            halted,
   output logic            led_red,
   output logic            led_green,
   output logic            led_blue
);

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int RW = $clog2(NREGS);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   // C_STOP covers EBREAK, unsupported encodings and out-of-range register indices.
   typedef enum logic [3:0] {
      C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLT, C_LUI, C_BEQ, C_BNE, C_JAL, C_STOP
   } cls_t;

   logic [31:0] imem [IMEM_DEPTH];

   state_t          state_q, state_d;
   cls_t            cls_q, cls_d;
   logic [DW-1:0]   div_cnt_q, div_cnt_d;
   logic [31:0]     pc_q, pc_d, ir_q, ir_d, imm_q, imm_d, npc_q, npc_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic            use_imm_q, use_imm_d, wr_q, wr_d, blue_q, blue_d;
   logic [15:0]     retired_q, retired_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   logic            tick;
   logic [4:0]      rd_idx, rs1_idx, rs2_idx;
   logic [2:0]      funct3;
   logic [6:0]      funct7, opcode;
   cls_t            dec_cls;
   logic [31:0]     dec_imm;
   logic            dec_use_imm, use_rs1, use_rs2, use_rd;
   logic [XLEN-1:0] op_b, exec_res;
   logic [31:0]     pc_plus4, target, exec_npc;
   logic            take, exec_stop;

   assign opcode  = ir_q[6:0];
   assign rd_idx  = ir_q[11:7];
   assign funct3  = ir_q[14:12];
   assign rs1_idx = ir_q[19:15];
   assign rs2_idx = ir_q[24:20];
   assign funct7  = ir_q[31:25];

   // Tick divider: holds while run is low, wraps on the tick cycle.
   always_comb begin
      tick      = run && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      if (run) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   // Instruction classification and immediate extraction from IR.
   always_comb begin
      dec_cls     = C_STOP;
      dec_imm     = 32'h0;
      dec_use_imm = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      use_rd      = 1'b0;
      case (opcode)
         7'h37: begin
            dec_cls = C_LUI;
            dec_imm = {ir_q[31:12], 12'h000};
            use_rd  = 1'b1;
         end
         7'h13: begin
            dec_imm     = {{20{ir_q[31]}}, ir_q[31:20]};
            dec_use_imm = 1'b1;
            use_rs1     = 1'b1;
            use_rd      = 1'b1;
            case (funct3)
               3'b000:  dec_cls = C_ADD;
               3'b111:  dec_cls = C_AND;
               3'b110:  dec_cls = C_OR;
               3'b100:  dec_cls = C_XOR;
               3'b010:  dec_cls = C_SLT;
               default: dec_cls = C_STOP;
            endcase
         end
         7'h33: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'b000:  dec_cls = C_ADD;
                  3'b111:  dec_cls = C_AND;
                  3'b110:  dec_cls = C_OR;
                  3'b100:  dec_cls = C_XOR;
                  3'b010:  dec_cls = C_SLT;
                  default: dec_cls = C_STOP;
               endcase
            end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
               dec_cls = C_SUB;
            end
         end
         7'h63: begin
            dec_imm = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            case (funct3)
               3'b000:  dec_cls = C_BEQ;
               3'b001:  dec_cls = C_BNE;
               default: dec_cls = C_STOP;
            endcase
         end
         7'h6f: begin
            dec_cls = C_JAL;
            dec_imm = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            use_rd  = 1'b1;
         end
         default: dec_cls = C_STOP;
      endcase
      if ((use_rs1 && {1'b0, rs1_idx} >= NREGS_L) ||
          (use_rs2 && {1'b0, rs2_idx} >= NREGS_L) ||
          (use_rd  && {1'b0, rd_idx}  >= NREGS_L))
         dec_cls = C_STOP;
   end

   // ALU, branch resolution and halt detection on the latched operands.
   always_comb begin
      op_b      = use_imm_q ? imm_q[XLEN-1:0] : b_q;
      pc_plus4  = pc_q + 32'd4;
      target    = pc_q + imm_q;
      exec_res  = '0;
      take      = 1'b0;
      case (cls_q)
         C_ADD:   exec_res = a_q + op_b;
         C_SUB:   exec_res = a_q - op_b;
         C_AND:   exec_res = a_q & op_b;
         C_OR:    exec_res = a_q | op_b;
         C_XOR:   exec_res = a_q ^ op_b;
         C_SLT:   exec_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(op_b)};
         C_LUI:   exec_res = imm_q[XLEN-1:0];
         C_BEQ:   take = (a_q == b_q);
         C_BNE:   take = (a_q != b_q);
         C_JAL: begin
            exec_res = pc_plus4[XLEN-1:0];
            take     = 1'b1;
         end
         default: exec_res = '0;
      endcase
      exec_npc  = take ? target : pc_plus4;
      exec_stop = (cls_q == C_STOP) || (take && target[1:0] != 2'b00);
   end

   // Next-state and architectural updates, one FSM step per tick.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      cls_d     = cls_q;
      use_imm_d = use_imm_q;
      wr_d      = wr_q;
      res_d     = res_q;
      npc_d     = npc_q;
      retired_d = retired_q;
      blue_d    = blue_q;
      regs_d    = regs_q;
      if (tick) begin
         case (state_q)
            S_FETCH: begin
               ir_d    = imem[pc_q[AW+1:2]];
               state_d = S_DECODE;
            end
            S_DECODE: begin
               a_d       = regs_q[rs1_idx[RW-1:0]];
               b_d       = regs_q[rs2_idx[RW-1:0]];
               imm_d     = dec_imm;
               cls_d     = dec_cls;
               use_imm_d = dec_use_imm;
               wr_d      = use_rd && (rd_idx != 5'd0);
               state_d   = S_EXEC;
            end
            S_EXEC: begin
               if (exec_stop) begin
                  state_d = S_HALT;
               end else begin
                  res_d   = exec_res;
                  npc_d   = exec_npc;
                  state_d = S_WB;
               end
            end
            S_WB: begin
               if (wr_q) regs_d[rd_idx[RW-1:0]] = res_q;
               pc_d      = npc_q;
               retired_d = retired_q + 16'd1;
               blue_d    = ~blue_q;
               state_d   = S_FETCH;
            end
            default: state_d = S_HALT;
         endcase
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_FETCH;
         div_cnt_q <= '0;
         pc_q      <= 32'h0;
         ir_q      <= 32'h0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= 32'h0;
         cls_q     <= C_STOP;
         use_imm_q <= 1'b0;
         wr_q      <= 1'b0;
         res_q     <= '0;
         npc_q     <= 32'h0;
         retired_q <= 16'h0;
         blue_q    <= 1'b0;
         regs_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         imm_q     <= imm_d;
         cls_q     <= cls_d;
         use_imm_q <= use_imm_d;
         wr_q      <= wr_d;
         res_q     <= res_d;
         npc_q     <= npc_d;
         retired_q <= retired_d;
         blue_q    <= blue_d;
         regs_q    <= regs_d;
      end
   end

   assign dbg_rdata = ({1'b0, dbg_raddr} < NREGS_L) ? regs_q[dbg_raddr[RW-1:0]] : '0;
   assign dbg_pc    = pc_q;
   assign dbg_ir    = ir_q;
   assign retired   = retired_q;
   assign halted    = (state_q == S_HALT);
   assign led_red   = halted;
   assign led_green = regs_q[1][0];
   assign led_blue  = blue_q;

endmodule
